// File: rtl/mips_abb_pkg.sv
// Shared MIPS datapath types plus the fetch-stage state encoding and
// redirect-select bit positions.
package mips_abb_pkg;

    typedef logic [31:0] instr_addr;
    typedef logic [31:0] instr_data;
    typedef logic [31:0] reg_word;

    localparam instr_data NONE = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } if_state;

    localparam int JSEL_BR = 0;
    localparam int JSEL_JR = 1;
    localparam int JSEL_J  = 2;

endpackage

// File: rtl/stage_if_if.sv
// Instruction-memory request/acknowledge port between the fetch stage
// (master) and the instruction memory (slave).
interface stage_if_if;
    import mips_abb_pkg::*;

    logic      imem_req;
    instr_addr imem_addr;
    logic      imem_ack;
    instr_data imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/stage_if_next_pc.sv
// Next-PC selection: redirect priority (branch > register jump > absolute
// jump), pending delay-slot target, or sequential pc+4.
module if_next_pc
    import mips_abb_pkg::*;
(
    input  logic [2:0] i_jsel,
    input  logic       i_id_stop,
    input  instr_addr  i_branch_addr,
    input  instr_addr  i_jc_addr,
    input  instr_addr  i_j_addr,
    input  instr_addr  i_pc,
    input  logic       i_redir_pend,
    input  instr_addr  i_redir_tgt,
    output logic       o_accept,
    output instr_addr  o_target,
    output instr_addr  o_next_pc
);

    always_comb begin
        o_target = i_j_addr;
        if (i_jsel[JSEL_BR]) begin
            o_target = i_branch_addr;
        end else if (i_jsel[JSEL_JR]) begin
            o_target = i_jc_addr;
        end else if (i_jsel[JSEL_J]) begin
            o_target = i_j_addr;
        end

        // Decode only commits a redirect when it is not itself stalled.
        o_accept = (i_jsel != 3'b000) && !i_id_stop;

        if (o_accept) begin
            o_next_pc = o_target;
        end else if (i_redir_pend) begin
            o_next_pc = i_redir_tgt;
        end else begin
            o_next_pc = i_pc + 32'd4;
        end
    end

endmodule

// File: rtl/stage_if.sv
// MIPS instruction-fetch stage with IF/ID pipeline register; the word at pc
// when a redirect is accepted is always delivered as the delay slot.
module stage_if
    import mips_abb_pkg::*;
#(
    parameter instr_addr PC_INIT = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    stage_if_if.master  imem,
    input  logic        id_stop,
    input  logic [2:0]  jsel,
    input  instr_addr   branch_addr,
    input  instr_addr   jc_addr,
    input  instr_addr   j_addr,
    output instr_addr   if_o_pc,
    output instr_addr   if_o_pc_4,
    output instr_data   if_o_instr,
    output logic        if_o_valid
);

    if_state   r_state;
    if_state   w_state_nxt;
    instr_addr r_pc;
    instr_addr r_redir_tgt;
    logic      r_redir_pend;
    instr_data r_hold_buf;

    logic      w_xfer;
    logic      w_load_hold;
    instr_data w_word;
    logic      w_accept;
    instr_addr w_target;
    instr_addr w_next_pc;

    assign imem.imem_req  = (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;

    if_next_pc u_next_pc (
        .i_jsel        (jsel),
        .i_id_stop     (id_stop),
        .i_branch_addr (branch_addr),
        .i_jc_addr     (jc_addr),
        .i_j_addr      (j_addr),
        .i_pc          (r_pc),
        .i_redir_pend  (r_redir_pend),
        .i_redir_tgt   (r_redir_tgt),
        .o_accept      (w_accept),
        .o_target      (w_target),
        .o_next_pc     (w_next_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_load_hold = 1'b0;
        w_word      = imem.imem_rdata;
        case (r_state)
            S_BOOT: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ack) begin
                    if (!id_stop) begin
                        w_xfer = 1'b1;
                    end else begin
                        // Park the word so a stall on the ack cycle loses nothing.
                        w_load_hold = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                w_word = r_hold_buf;
                if (!id_stop) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_pc         <= PC_INIT;
            r_redir_pend <= 1'b0;
        end else if (w_xfer) begin
            r_pc         <= w_next_pc;
            r_redir_pend <= 1'b0;
        end else if (w_accept) begin
            r_redir_pend <= 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst && !w_xfer && w_accept) begin
            r_redir_tgt <= w_target;
        end
        if (!cpu_rst && w_load_hold) begin
            r_hold_buf <= imem.imem_rdata;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            if_o_pc    <= '0;
            if_o_pc_4  <= '0;
            if_o_instr <= NONE;
            if_o_valid <= 1'b0;
        end else if (w_xfer) begin
            if_o_pc    <= r_pc;
            if_o_pc_4  <= r_pc + 32'd4;
            if_o_instr <= w_word;
            if_o_valid <= 1'b1;
        end else if (!id_stop) begin
            if_o_instr <= NONE;
            if_o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed vector bench for stage_if: fetch timing, wait states, stall-on-ack,
// redirects with delay slot, priority, reset mid-fetch and pc wrap.
module tb_stage_if;
    import mips_abb_pkg::*;

    typedef struct {
        logic        rst, ack, stop;
        logic [2:0]  jsel;
        logic [31:0] br, jc, j;
        logic        chk, ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc, epc4, einstr;
    } vec_t;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        id_stop;
    logic [2:0]  jsel;
    logic [31:0] branch_addr, jc_addr, j_addr;
    logic [31:0] if_o_pc, if_o_pc_4, if_o_instr;
    logic        if_o_valid;

    stage_if_if bus ();

    stage_if #(.PC_INIT(32'h0000_0000)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .imem        (bus),
        .id_stop     (id_stop),
        .jsel        (jsel),
        .branch_addr (branch_addr),
        .jc_addr     (jc_addr),
        .j_addr      (j_addr),
        .if_o_pc     (if_o_pc),
        .if_o_pc_4   (if_o_pc_4),
        .if_o_instr  (if_o_instr),
        .if_o_valid  (if_o_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h2408_0005 : (32'hA000_0000 | a);
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic rst, ack, stop, input logic [2:0] js,
                       input logic [31:0] br, jc, j, input logic chk, ereq,
                       input logic [31:0] eaddr, input logic evalid,
                       input logic [31:0] epc, epc4, einstr);
        vec_t v;
        v.rst = rst; v.ack = ack; v.stop = stop; v.jsel = js;
        v.br = br; v.jc = jc; v.j = j; v.chk = chk; v.ereq = ereq;
        v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.epc4 = epc4;
        v.einstr = einstr;
        vq.push_back(v);
    endtask

    task automatic cmp(input int idx, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge cpu_clk);
        cpu_rst      = v.rst;
        bus.imem_ack = v.ack;
        id_stop      = v.stop;
        jsel         = v.jsel;
        branch_addr  = v.br;
        jc_addr      = v.jc;
        j_addr       = v.j;
        #1;
        if (v.chk) begin
            n_vec++;
            cmp(idx, "req",   {31'd0, bus.imem_req}, {31'd0, v.ereq});
            cmp(idx, "addr",  bus.imem_addr, v.eaddr);
            cmp(idx, "valid", {31'd0, if_o_valid}, {31'd0, v.evalid});
            cmp(idx, "pc",    if_o_pc, v.epc);
            cmp(idx, "pc4",   if_o_pc_4, v.epc4);
            cmp(idx, "instr", if_o_instr, v.einstr);
        end
    endtask

    initial begin
        vec_t h;
        cpu_rst = 1'b1; bus.imem_ack = 1'b0; id_stop = 1'b0; jsel = 3'b000;
        branch_addr = '0; jc_addr = '0; j_addr = '0;

        //  rst ack stp jsel  br      jc     j            chk req addr         vld pc           pc4      instr
        add(1, 0, 0, 3'b000, 0,      0,     0,           0, 0, 0,           0, 0,           0,       0);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 0, 0,           0, 0,           0,       0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 0,           0, 0,           0,       0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h4,       1, 32'h0,       32'h4,   32'hA000_0000);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 1, 32'h8,       1, 32'h4,       32'h8,   32'hA000_0004);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 1, 32'h8,       0, 32'h4,       32'h8,   0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h8,       0, 32'h4,       32'h8,   0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'hC,       1, 32'h8,       32'hC,   32'hA000_0008);
        add(0, 1, 1, 3'b000, 0,      0,     0,           1, 1, 32'h10,      1, 32'hC,       32'h10,  32'hA000_000C);
        add(0, 0, 1, 3'b000, 0,      0,     0,           1, 0, 32'h10,      1, 32'hC,       32'h10,  32'hA000_000C);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 0, 32'h10,      1, 32'hC,       32'h10,  32'hA000_000C);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h14,      1, 32'h10,      32'h14,  32'h2408_0005);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h18,      1, 32'h14,      32'h18,  32'hA000_0014);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h1C,      1, 32'h18,      32'h1C,  32'hA000_0018);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h20,      1, 32'h1C,      32'h20,  32'hA000_001C);
        add(0, 1, 0, 3'b001, 32'h100, 0,    0,           1, 1, 32'h24,      1, 32'h20,      32'h24,  32'hA000_0020);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h100,     1, 32'h24,      32'h28,  32'hA000_0024);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h104,     1, 32'h100,     32'h104, 32'hA000_0100);
        add(0, 0, 0, 3'b100, 0,      0,     32'h400,     1, 1, 32'h108,     1, 32'h104,     32'h108, 32'hA000_0104);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 1, 32'h108,     0, 32'h104,     32'h108, 0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h108,     0, 32'h104,     32'h108, 0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h400,     1, 32'h108,     32'h10C, 32'hA000_0108);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h404,     1, 32'h400,     32'h404, 32'hA000_0400);
        add(0, 1, 0, 3'b111, 32'h40, 32'h80, 32'hC0,     1, 1, 32'h408,     1, 32'h404,     32'h408, 32'hA000_0404);
        add(0, 1, 0, 3'b110, 32'h200, 32'h80, 32'hC0,    1, 1, 32'h40,      1, 32'h408,     32'h40C, 32'hA000_0408);
        add(0, 1, 1, 3'b001, 32'h300, 0,    0,           1, 1, 32'h80,      1, 32'h40,      32'h44,  32'hA000_0040);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 0, 32'h80,      1, 32'h40,      32'h44,  32'hA000_0040);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 1, 32'h84,      1, 32'h80,      32'h84,  32'hA000_0080);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 1, 32'h84,      0, 32'h80,      32'h84,  0);
        add(1, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h84,      0, 32'h80,      32'h84,  0);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 0, 0,           0, 0,           0,       0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 0,           0, 0,           0,       0);
        add(0, 0, 0, 3'b100, 0,      0,     32'hFFFF_FFFC, 1, 1, 32'h4,     1, 32'h0,       32'h4,   32'hA000_0000);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'h4,       0, 32'h0,       32'h4,   0);
        add(0, 1, 0, 3'b000, 0,      0,     0,           1, 1, 32'hFFFF_FFFC, 1, 32'h4,     32'h8,   32'hA000_0004);
        add(0, 0, 0, 3'b000, 0,      0,     0,           1, 1, 32'h0,       1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);

        for (int i = 0; i < vq.size(); i++) begin
            apply(i, vq[i]);
        end

        // Decode stall while a fetch is outstanding: a valid IF/ID entry must hold.
        h = vq[0];
        h.rst = 0; h.stop = 0; h.jsel = 3'b000; h.br = 0; h.jc = 0; h.j = 0; h.chk = 1;
        h.ack = 1; h.ereq = 1; h.eaddr = 32'h0; h.evalid = 0;
        h.epc = 32'hFFFF_FFFC; h.epc4 = 32'h0; h.einstr = 0;
        apply(100, h);
        h.ack = 0; h.stop = 1; h.eaddr = 32'h4; h.evalid = 1;
        h.epc = 32'h0; h.epc4 = 32'h4; h.einstr = 32'hA000_0000;
        apply(101, h);
        apply(102, h);
        h.ack = 1; h.stop = 0;
        apply(103, h);
        h.ack = 0; h.eaddr = 32'h8; h.epc = 32'h4; h.epc4 = 32'h8; h.einstr = 32'hA000_0004;
        apply(104, h);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
